seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Upstream feeder for the serial sequence detector. Accepts parallel words over a valid/ready handshake and emits them one bit per clock on sout, which drives the detector's serial input x.
- Uses a one-word holding buffer plus a shift register, so back-to-back words stream with no gap bits.
- When no data is available, sout carries a fixed idle level. A 1 is chosen because the detector stays in its initial state on 1s, so idle periods cannot form a false match.

Parameters:
- WIDTH, 8, bits per input word (legal range 2..32).
- MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = shift out din[0] first.
- IDLE_BIT, 1, value driven on sout when no word is being shifted.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial bit stream to the detector's x input.
- sout_valid  output  1  sout is a data bit; 0 means sout is the idle fill.
- word_done  output  1  single-cycle pulse, high while the last bit of a word is on sout.
- busy  output  1  hold buffer or shifter occupied.

Behaviour:
- Registers: hold_reg[WIDTH], hold_full, shreg[WIDTH], bit_cnt[$clog2(WIDTH)], state in {IDLE, SHIFT}.
- Reset (asynchronous assert, synchronous release):
  - hold_full=0, state=IDLE, bit_cnt=0, shreg=0.
  - sout=IDLE_BIT, sout_valid=0, word_done=0, busy=0, din_ready=1.
- Accept: a transfer occurs on an edge where din_valid && din_ready; din is captured into hold_reg and hold_full is set.
- din_ready = !hold_full || load. It does not depend on din_valid.
- load = hold_full && (state==IDLE || (state==SHIFT && bit_cnt==WIDTH-1)).
- On an edge with load:
  - shreg <= hold_reg, bit_cnt <= 0, state <= SHIFT.
  - hold_full is cleared unless a new word is accepted on the same edge; in that case it stays 1 and hold_reg takes the new din.
- sout is driven combinationally from registers:
  - In SHIFT: sout = shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - In IDLE: sout = IDLE_BIT.
  - sout_valid = (state==SHIFT).
- Each edge in SHIFT without load: shreg shifts toward the output end (zero fill) and bit_cnt increments.
- word_done = (state==SHIFT && bit_cnt==WIDTH-1).
- At bit_cnt==WIDTH-1 without load: state <= IDLE.
- Latency: a word accepted on edge E into an idle block puts its first bit on sout after edge E+1. Its last bit is on sout after edge E+WIDTH.
- Throughput: one word per WIDTH cycles. A word waiting in hold_reg produces a continuous bit stream with no idle bit between words.
- Simultaneous accept and load (hold full, last bit being sent): both happen on the same edge, and no word is lost or duplicated.
- din_valid held with din_ready low: no capture. din may change freely while not being accepted.
- busy = hold_full || state==SHIFT.
- Reset mid-word: the partial word and the held word are discarded. sout returns to IDLE_BIT immediately, asynchronously with reset.
- bit_cnt never exceeds WIDTH-1. No wrap-around states exist beyond IDLE and SHIFT; an illegal encoding returns to IDLE.

Decomposition:
- Shared package seq_pkg: state enum (IDLE, SHIFT) and a default word-width constant. The detector's pattern constant (01101) also goes here, for use by benches.
- Single flat module; no sub-module warranted.

Test Plan:
- Reset release, din_valid=0 for 10 cycles -> sout=1, sout_valid=0, din_ready=1, busy=0 throughout.
- WIDTH=8, MSB_FIRST=1, single word 8'h68 -> sout = 0,1,1,0,1,0,0,0 starting two edges after acceptance. word_done high on the 8th bit only. The downstream detector z pulses on the 5th bit.
- Two words 8'hA5 then 8'h3C offered continuously -> 16 consecutive valid bits with no idle gap. The second word is accepted on the first word's load edge. din_ready drops to 0 until the final-bit edge of word 1.
- MSB_FIRST=0, word 8'h01 -> sout = 1,0,0,0,0,0,0,0.
- Reset asserted at bit 3 of a word with a second word held -> sout=1 and sout_valid=0 immediately. After release, neither word is emitted and din_ready=1.
- Random valid gaps over 1000 words -> serial stream reassembles exactly to the input words. The count of sout_valid cycles equals 8×words, and the count of word_done pulses equals words.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence path.
// Holds the serializer state encoding and the detector pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b01,
        SHIFT = 2'b10
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Sequence the downstream detector matches on x.
    localparam logic [4:0] DETECT_PATTERN = 5'b01101;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// One-word hold buffer plus shifter gives gapless streaming.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             in_shift;
    logic             last_bit;
    logic             load;
    logic             accept;

    assign in_shift  = (state == SHIFT);
    assign last_bit  = in_shift && (bit_cnt == LAST_CNT);
    // Reload on the final-bit edge so the next word follows with no gap.
    assign load      = hold_full && ((state == IDLE) || last_bit);
    assign din_ready = !hold_full || load;
    assign accept    = din_valid && din_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; any unknown encoding falls back to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                state_nxt = load ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (load) begin
                    state_nxt = SHIFT;
                end else if (last_bit) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Serial outputs, driven from registers only.
    always_comb begin
        sout       = IDLE_BIT;
        sout_valid = 1'b0;
        word_done  = 1'b0;
        busy       = hold_full || in_shift;
        if (in_shift) begin
            sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
            sout_valid = 1'b1;
            word_done  = last_bit;
        end
    end

    // Hold buffer: a new word may land on the same edge the old one loads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_reg  <= din;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Shifter and bit counter, zero fill behind the output end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            shreg   <= hold_reg;
            bit_cnt <= '0;
        end else if (in_shift) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer.
// Two instances: MSB-first and LSB-first, sharing clock and reset.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] din_m;
    logic         valid_m;
    logic         ready_m;
    logic         sout_m;
    logic         sv_m;
    logic         wd_m;
    logic         busy_m;
    logic [W-1:0] din_l;
    logic         valid_l;
    logic         ready_l;
    logic         sout_l;
    logic         sv_l;
    logic         wd_l;
    logic         busy_l;

    int vectors     = 0;
    int miscompares = 0;
    int vcnt_m      = 0;
    int dcnt_m      = 0;
    int vcnt_l      = 0;

    // Entries are {word_done, sout}.
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic [1:0] e_m;
    logic [1:0] e_l;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_m (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(valid_m),
        .din_ready(ready_m), .sout(sout_m), .sout_valid(sv_m),
        .word_done(wd_m), .busy(busy_m)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(valid_l),
        .din_ready(ready_l), .sout(sout_l), .sout_valid(sv_l),
        .word_done(wd_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stream monitor, MSB-first instance.
    always @(negedge clk) begin
        vectors++;
        if (sv_m === 1'b1) begin
            vcnt_m++;
            if (wd_m === 1'b1) dcnt_m++;
            if (q_m.size() == 0) begin
                miscompares++;
                $display("FAIL stream_m: got bit %b done %b, required no valid bit", sout_m, wd_m);
            end else begin
                e_m = q_m.pop_front();
                if ({wd_m, sout_m} !== e_m) begin
                    miscompares++;
                    $display("FAIL stream_m: got done,bit=%b%b required %b", wd_m, sout_m, e_m);
                end
            end
        end else if (sout_m !== 1'b1 || wd_m !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_m: got sout=%b done=%b required 1,0", sout_m, wd_m);
        end
    end

    // Stream monitor, LSB-first instance.
    always @(negedge clk) begin
        vectors++;
        if (sv_l === 1'b1) begin
            vcnt_l++;
            if (q_l.size() == 0) begin
                miscompares++;
                $display("FAIL stream_l: got bit %b done %b, required no valid bit", sout_l, wd_l);
            end else begin
                e_l = q_l.pop_front();
                if ({wd_l, sout_l} !== e_l) begin
                    miscompares++;
                    $display("FAIL stream_l: got done,bit=%b%b required %b", wd_l, sout_l, e_l);
                end
            end
        end else if (sout_l !== 1'b1 || wd_l !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_l: got sout=%b done=%b required 1,0", sout_l, wd_l);
        end
    end

    task automatic push(input bit sel, input logic [W-1:0] w);
        logic b;
        for (int i = 0; i < W; i++) begin
            b = sel ? w[i] : w[W-1-i];
            if (sel) q_l.push_back({i == W - 1, b});
            else     q_m.push_back({i == W - 1, b});
        end
    endtask

    // Offer a word; junk on din while the block is not ready.
    task automatic offer(input bit sel, input logic [W-1:0] w);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if ((sel ? ready_l : ready_m) === 1'b1) begin
                if (sel) begin din_l = w; valid_l = 1'b1; end
                else     begin din_m = w; valid_m = 1'b1; end
                push(sel, w);
                done = 1'b1;
            end else begin
                if (sel) begin din_l = W'($urandom); valid_l = 1'b1; end
                else     begin din_m = W'($urandom); valid_m = 1'b1; end
                n++;
                if (n > 4 * W) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL offer_timeout: din_ready stayed 0 for %0d cycles, required 1", n);
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic gap(input bit sel, input int n);
        repeat (n) begin
            @(negedge clk);
            if (sel) begin din_l = W'($urandom); valid_l = 1'b0; end
            else     begin din_m = W'($urandom); valid_m = 1'b0; end
        end
    endtask

    task automatic drain(input bit sel);
        int n;
        n = 0;
        gap(sel, 1);
        while (((sel ? busy_l : busy_m) !== 1'b0 || (sel ? sv_l : sv_m) !== 1'b0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 100 || (sel ? q_l.size() : q_m.size()) != 0) begin
            miscompares++;
            $display("FAIL drain: waited %0d cycles, %0d bits left, required idle and 0",
                     n, sel ? q_l.size() : q_m.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (sout_m !== 1'b1 || sv_m !== 1'b0 || ready_m !== 1'b1 || busy_m !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle: sout,sv,ready,busy=%b%b%b%b required 1010",
                         sout_m, sv_m, ready_m, busy_m);
            end
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] got;
        got = '0;
        offer(1'b0, 8'h68);
        gap(1'b0, 1);
        vectors++;
        if (sv_m !== 1'b0 || busy_m !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: sv=%b busy=%b required 0,1", sv_m, busy_m);
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            got[W-1-i] = sout_m;
            vectors++;
            if (sv_m !== 1'b1) begin
                miscompares++;
                $display("FAIL single_valid: bit %0d sv=%b required 1", i, sv_m);
            end
        end
        vectors++;
        if (got !== 8'h68) begin
            miscompares++;
            $display("FAIL single_word: got %h required 68", got);
        end
        vectors++;
        if (got[W-1:W-5] !== DETECT_PATTERN) begin
            miscompares++;
            $display("FAIL single_pattern: got %b required %b", got[W-1:W-5], DETECT_PATTERN);
        end
        drain(1'b0);
    endtask

    task automatic test_back_to_back();
        int low_cnt;
        int run;
        int max_run;
        low_cnt = 0;
        run     = 0;
        max_run = 0;
        offer(1'b0, 8'hA5);
        offer(1'b0, 8'h3C);
        @(negedge clk);
        valid_m = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready_m !== 1'b1) low_cnt++;
            if (sv_m === 1'b1) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            @(negedge clk);
        end
        vectors++;
        if (max_run != 2 * W) begin
            miscompares++;
            $display("FAIL b2b_run: got %0d consecutive bits required %0d", max_run, 2 * W);
        end
        vectors++;
        if (low_cnt != W - 1) begin
            miscompares++;
            $display("FAIL b2b_ready: got %0d ready-low cycles required %0d", low_cnt, W - 1);
        end
        drain(1'b0);
    endtask

    task automatic test_lsb_first();
        vcnt_l = 0;
        offer(1'b1, 8'h01);
        drain(1'b1);
        vectors++;
        if (vcnt_l != W) begin
            miscompares++;
            $display("FAIL lsb_count: got %0d bits required %0d", vcnt_l, W);
        end
    endtask

    task automatic test_reset_mid_word();
        int seen;
        seen = 0;
        offer(1'b0, 8'hC3);
        offer(1'b0, 8'h5A);
        gap(1'b0, 4);
        vectors++;
        if (sv_m !== 1'b1 || busy_m !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_active: sv=%b busy=%b required 1,1", sv_m, busy_m);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (sout_m !== 1'b1 || sv_m !== 1'b0 || ready_m !== 1'b1 || busy_m !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: sout,sv,ready,busy=%b%b%b%b required 1010",
                     sout_m, sv_m, ready_m, busy_m);
        end
        q_m.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sv_m === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || ready_m !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_discard: got %0d bits ready=%b required 0 bits ready=1",
                     seen, ready_m);
        end
    endtask

    task automatic test_random_stream();
        vcnt_m = 0;
        dcnt_m = 0;
        for (int i = 0; i < 1000; i++) begin
            gap(1'b0, $urandom_range(0, 2));
            offer(1'b0, W'($urandom));
        end
        drain(1'b0);
        vectors++;
        if (vcnt_m != 1000 * W) begin
            miscompares++;
            $display("FAIL rand_bits: got %0d valid cycles required %0d", vcnt_m, 1000 * W);
        end
        vectors++;
        if (dcnt_m != 1000) begin
            miscompares++;
            $display("FAIL rand_done: got %0d word_done pulses required 1000", dcnt_m);
        end
    endtask

    initial begin
        reset   = 1'b1;
        din_m   = '0;
        valid_m = 1'b0;
        din_l   = '0;
        valid_l = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_reset_mid_word();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
